// File: rtl/bsg_link_credit_tracker.sv
// Multi-channel token-credit tracker for the upstream side of the off-chip link.
// Optional statistics/overflow logic is built when BSG_LINK_CREDIT_STATS_EN is defined.
module bsg_link_credit_tracker #(
    parameter int NUM_CH         = 2,
    parameter int CREDIT_DEPTH   = 64,
    parameter int TOKEN_RATIO_LG = 3,
    parameter int TOKEN_SYNC     = 2,
    parameter int CNT_W          = 7,
    localparam int CW            = $clog2(CREDIT_DEPTH + 1),
    localparam int SW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    token_i,
    input  logic                 core_valid_i,
    output logic                 core_ready_o,
    output logic [NUM_CH-1:0]    send_o,
    output logic [SW-1:0]        ch_sel_o,
    output logic [NUM_CH*CW-1:0] credit_o,
    output logic                 overflow_o,
    output logic [CNT_W-1:0]     sent_cnt_o,
    output logic [CNT_W-1:0]     returned_cnt_o
);

    localparam logic [CW:0]   DEPTH_X = (CW + 1)'(CREDIT_DEPTH);
    localparam logic [CW:0]   INC_X   = (CW + 1)'(2 ** TOKEN_RATIO_LG);
    localparam logic [SW-1:0] LAST_CH = SW'(NUM_CH - 1);

    logic [NUM_CH-1:0] r_sync [TOKEN_SYNC];
    logic [NUM_CH-1:0] r_hist;
    logic [CW-1:0]     r_credit [NUM_CH];
    logic [SW-1:0]     r_ch_sel;

    logic [NUM_CH-1:0] w_edge;
    logic              w_xfer;
    logic [NUM_CH-1:0] w_send;
    logic [CW:0]       w_sum [NUM_CH];
    logic [CW-1:0]     w_next_credit [NUM_CH];

    // Token wires are asynchronous; each level change is one token.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < TOKEN_SYNC; s++) begin
                r_sync[s] <= '0;
            end
            r_hist <= '0;
        end else begin
            r_sync[0] <= token_i;
            for (int s = 1; s < TOKEN_SYNC; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_hist <= r_sync[TOKEN_SYNC-1];
        end
    end

    assign w_edge = r_sync[TOKEN_SYNC-1] ^ r_hist;

    // valid/ready: a word transfers in any cycle where core_valid_i & core_ready_o;
    // ready depends only on registered credit of the current channel, never on valid.
    assign core_ready_o = (r_credit[r_ch_sel] != '0);
    assign w_xfer       = core_valid_i & core_ready_o;

    always_comb begin
        w_send = '0;
        if (w_xfer) begin
            w_send[r_ch_sel] = 1'b1;
        end
    end

    // Send and token on the same channel apply together; result saturates at full depth.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum[i] = {1'b0, r_credit[i]} - (CW + 1)'(w_send[i])
                     + (w_edge[i] ? INC_X : '0);
            if (w_sum[i] > DEPTH_X) begin
                w_next_credit[i] = DEPTH_X[CW-1:0];
            end else begin
                w_next_credit[i] = w_sum[i][CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_credit[i] <= DEPTH_X[CW-1:0];
            end
            r_ch_sel <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_credit[i] <= w_next_credit[i];
            end
            if (w_xfer) begin
                r_ch_sel <= (r_ch_sel == LAST_CH) ? '0 : r_ch_sel + 1'b1;
            end
        end
    end

    always_comb begin
        credit_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            credit_o[i*CW +: CW] = r_credit[i];
        end
    end

    assign send_o   = w_send;
    assign ch_sel_o = r_ch_sel;

`ifdef BSG_LINK_CREDIT_STATS_EN
    logic             r_overflow;
    logic [CNT_W-1:0] r_sent_cnt;
    logic [CNT_W-1:0] r_returned_cnt;
    logic [CNT_W-1:0] w_ret_inc;
    logic             w_any_over;

    always_comb begin
        w_ret_inc  = '0;
        w_any_over = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_edge[i]) begin
                w_ret_inc = w_ret_inc + CNT_W'(2 ** TOKEN_RATIO_LG);
            end
            if (w_sum[i] > DEPTH_X) begin
                w_any_over = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow     <= 1'b0;
            r_sent_cnt     <= '0;
            r_returned_cnt <= '0;
        end else begin
            if (w_any_over) begin
                r_overflow <= 1'b1;
            end
            if (w_xfer) begin
                r_sent_cnt <= r_sent_cnt + 1'b1;
            end
            r_returned_cnt <= r_returned_cnt + w_ret_inc;
        end
    end

    assign overflow_o     = r_overflow;
    assign sent_cnt_o     = r_sent_cnt;
    assign returned_cnt_o = r_returned_cnt;
`else
    assign overflow_o     = 1'b0;
    assign sent_cnt_o     = '0;
    assign returned_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_link_credit_tracker.sv
// Directed bench for bsg_link_credit_tracker at default parameters (2 channels, 64 credits).
// Statistics expectations follow BSG_LINK_CREDIT_STATS_EN the same way the design does.
module tb_bsg_link_credit_tracker;

    localparam int CW = 7;

    logic          clk;
    logic          rst;
    logic [1:0]    token_i;
    logic          core_valid_i;
    logic          core_ready_o;
    logic [1:0]    send_o;
    logic [0:0]    ch_sel_o;
    logic [2*CW-1:0] credit_o;
    logic          overflow_o;
    logic [6:0]    sent_cnt_o;
    logic [6:0]    returned_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    bsg_link_credit_tracker dut (
        .clk            (clk),
        .rst            (rst),
        .token_i        (token_i),
        .core_valid_i   (core_valid_i),
        .core_ready_o   (core_ready_o),
        .send_o         (send_o),
        .ch_sel_o       (ch_sel_o),
        .credit_o       (credit_o),
        .overflow_o     (overflow_o),
        .sent_cnt_o     (sent_cnt_o),
        .returned_cnt_o (returned_cnt_o)
    );

    // Clock / reset-independent watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crd(input int ch);
        return 32'(credit_o[ch*CW +: CW]);
    endfunction

    function automatic logic [31:0] stat_exp(input int v);
`ifdef BSG_LINK_CREDIT_STATS_EN
        return 32'(v % 128);
`else
        return 32'(v * 0);
`endif
    endfunction

    // One token per call; waits long enough for the credit update to land.
    task automatic tok_pulse(input int ch);
        token_i[ch] = ~token_i[ch];
        repeat (4) tick();
    endtask

    initial begin
        rst          = 1'b0;
        token_i      = 2'b00;
        core_valid_i = 1'b0;
        repeat (3) tick();
        check("rst_credit0_async", crd(0), 64);
        rst = 1'b1;
        tick();

        check("reset_ready", 32'(core_ready_o), 1);
        check("reset_credit0", crd(0), 64);
        check("reset_credit1", crd(1), 64);
        check("reset_ch_sel", 32'(ch_sel_o), 0);
        check("reset_overflow", 32'(overflow_o), 0);
        check("reset_sent", 32'(sent_cnt_o), 0);
        check("reset_returned", 32'(returned_cnt_o), 0);
        check("reset_send_idle", 32'(send_o), 0);

        // 128 back-to-back transfers, alternating channels
        core_valid_i = 1'b1;
        for (int k = 0; k < 128; k++) begin
            #1;
            check("drain_send", 32'(send_o), (k % 2 == 0) ? 1 : 2);
            if (k == 2) begin
                check("drain_credit0_k2", crd(0), 63);
                check("drain_credit1_k2", crd(1), 63);
                check("drain_ch_sel_k2", 32'(ch_sel_o), 0);
            end
            tick();
        end
        #1;
        check("drained_ready", 32'(core_ready_o), 0);
        check("drained_send", 32'(send_o), 0);
        check("drained_credit0", crd(0), 0);
        check("drained_credit1", crd(1), 0);
        check("drained_ch_sel", 32'(ch_sel_o), 0);
        check("drained_sent", 32'(sent_cnt_o), stat_exp(128));
        core_valid_i = 1'b0;

        // Token toggle on channel 0: sampled next edge, credited TOKEN_SYNC edges later
        token_i[0] = 1'b1;
        tick();
        tick();
        check("tok0_latency_pre", crd(0), 0);
        tick();
        check("tok0_first_edge", crd(0), 8);
        check("tok0_returned", 32'(returned_cnt_o), stat_exp(8));
        check("tok0_ready", 32'(core_ready_o), 1);
        tok_pulse(0);
        check("tok0_second_edge", crd(0), 16);
        check("tok0_returned2", 32'(returned_cnt_o), stat_exp(16));

        // Stall: channel 0 drained while channel 1 still holds credit
        tok_pulse(1);
        tok_pulse(1);
        tok_pulse(1);
        check("tok1_x3_credit", crd(1), 24);
        check("tok1_x3_returned", 32'(returned_cnt_o), stat_exp(40));
        core_valid_i = 1'b1;
        repeat (32) tick();
        check("stall_ready", 32'(core_ready_o), 0);
        check("stall_credit0", crd(0), 0);
        check("stall_credit1", crd(1), 8);
        check("stall_ch_sel", 32'(ch_sel_o), 0);
        check("stall_send", 32'(send_o), 0);
        tick();
        tick();
        check("stall_credit1_hold", crd(1), 8);
        check("stall_sent", 32'(sent_cnt_o), stat_exp(32));
        core_valid_i = 1'b0;

        // Same-cycle send and token on channel 1 (credit 5 -> 12)
        tok_pulse(0);
        check("refill_credit0", crd(0), 8);
        core_valid_i = 1'b1;
        repeat (7) tick();
        core_valid_i = 1'b0;
        check("pre_same_credit0", crd(0), 4);
        check("pre_same_credit1", crd(1), 5);
        check("pre_same_ch_sel", 32'(ch_sel_o), 1);
        token_i[1] = ~token_i[1];
        tick();
        tick();
        core_valid_i = 1'b1;
        #1;
        check("same_send", 32'(send_o), 2);
        tick();
        core_valid_i = 1'b0;
        check("same_credit1", crd(1), 12);
        check("same_credit0", crd(0), 4);
        check("same_ch_sel", 32'(ch_sel_o), 0);
        check("same_returned", 32'(returned_cnt_o), stat_exp(56));
        check("same_sent", 32'(sent_cnt_o), stat_exp(40));

        // Build credits 3 / 44, then reset with a token in the synchroniser
        repeat (4) tok_pulse(1);
        core_valid_i = 1'b1;
        tick();
        core_valid_i = 1'b0;
        check("prerst_credit0", crd(0), 3);
        check("prerst_credit1", crd(1), 44);
        check("prerst_ch_sel", 32'(ch_sel_o), 1);
        check("prerst_returned", 32'(returned_cnt_o), stat_exp(88));
        check("prerst_sent", 32'(sent_cnt_o), stat_exp(41));
        token_i[0] = ~token_i[0];
        tick();
        rst = 1'b0;
        #1;
        check("midrst_credit0", crd(0), 64);
        check("midrst_credit1", crd(1), 64);
        check("midrst_ch_sel", 32'(ch_sel_o), 0);
        check("midrst_ready", 32'(core_ready_o), 1);
        check("midrst_sent", 32'(sent_cnt_o), 0);
        check("midrst_returned", 32'(returned_cnt_o), 0);
        token_i = 2'b00;
        tick();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        check("postrst_credit0", crd(0), 64);
        check("postrst_credit1", crd(1), 64);
        check("postrst_returned", 32'(returned_cnt_o), 0);
        check("postrst_overflow", 32'(overflow_o), 0);

        // Token onto a full channel: saturates, overflow sticky until reset
        tok_pulse(0);
        check("ovf_credit0", crd(0), 64);
        check("ovf_flag", 32'(overflow_o), stat_exp(1));
        check("ovf_returned", 32'(returned_cnt_o), stat_exp(8));
        tok_pulse(1);
        check("ovf_credit1", crd(1), 64);
        repeat (3) tick();
        check("ovf_sticky", 32'(overflow_o), stat_exp(1));
        rst = 1'b0;
        #1;
        check("ovf_cleared", 32'(overflow_o), 0);
        tick();
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
